ysyx_wb_arb: RTL

YSYX_WB_ARB -- requirements
Module: ysyx_wb_arb

---
 rtl/ysyx_wb_arb.sv | 89 ++++++++
 1 files changed

// File: rtl/ysyx_wb_arb.sv
// Write-back arbiter: three requesters, each with a one-entry skid buffer, share
// one register-file write port through a round-robin grant and a registered output.
module ysyx_wb_arb #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      bad_speculation,
  input  logic [2:0]                req_valid,
  input  logic [3*REG_ADDR_W-1:0]   req_rd,
  input  logic [3*XLEN-1:0]         req_data,
  output logic [2:0]                req_ready,
  output logic                      wb_en,
  output logic [REG_ADDR_W-1:0]     wb_addr,
  output logic [XLEN-1:0]           wb_data,
  output logic                      busy
);

  // Handshake: requester i transfers on an edge where req_valid[i] & req_ready[i].
  // req_ready depends only on buffer state, grant and flush, never on req_valid.

  logic [2:0]            full;
  logic [REG_ADDR_W-1:0] buf_rd   [3];
  logic [XLEN-1:0]       buf_data [3];
  logic [1:0]            ptr;

  logic [2:0] grant;
  logic [1:0] gnt_sel;
  logic       found;
  logic [2:0] sum;
  logic [2:0] accept;

  // Round-robin search starting at ptr; the flush suppresses any grant.
  always_comb begin
    grant   = 3'b000;
    gnt_sel = 2'd0;
    found   = 1'b0;
    sum     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && full[sum[1:0]] && !bad_speculation) begin
        found             = 1'b1;
        gnt_sel           = sum[1:0];
        grant[sum[1:0]]   = 1'b1;
      end
    end
  end

  assign req_ready = (~full | grant) & {3{~bad_speculation}};
  assign accept    = req_valid & req_ready;
  assign busy      = |full;

  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= 3'b000;
      ptr     <= 2'd0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else if (bad_speculation) begin
      full  <= 3'b000;
      wb_en <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // A refill in the same cycle as a drain keeps the buffer full.
        if (accept[i] && (req_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
          full[i]     <= 1'b1;
          buf_rd[i]   <= req_rd[i*REG_ADDR_W +: REG_ADDR_W];
          buf_data[i] <= req_data[i*XLEN +: XLEN];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
      wb_en <= found;
      if (found) begin
        wb_addr <= buf_rd[gnt_sel];
        wb_data <= buf_data[gnt_sel];
        ptr     <= (gnt_sel == 2'd2) ? 2'd0 : gnt_sel + 2'd1;
      end
    end
  end

endmodule
